score_counter: RTL and testbench
================================

# score_counter

Game score keeper for the snake design. Counts food-eaten events into a saturating binary score and tracks the session high score. Drives the 8-bit value consumed by the dual 7-segment display stage, which splits it into tens and ones digits. On game over, the display value alternates between the final score and the high score.

## Interface

Parameters:
- MAX_SCORE, 99: saturation ceiling. Must be ≤ 99, because the display stage shows two digits.
- POINTS_PER_FOOD, 1: score added per eat event. Range 1..MAX_SCORE.
- SHOW_CYCLES, 25_000_000: clocks each value is held during game-over alternation (1 s at 25 MHz). Minimum 1.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- game_start  in  1  single-cycle pulse: start or restart a game
- eat_pulse  in  1  single-cycle pulse: snake ate food
- game_over  in  1  single-cycle pulse: collision detected
- score  out  8  current score, binary, 0..MAX_SCORE
- high_score  out  8  best score this power-up
- new_high  out  1  the last finished game set a new high score
- display_score  out  8  registered value for the 7-segment stage
- playing  out  1  high while in PLAYING

## Operation

- FSM states: IDLE, PLAYING, OVER. Reset state is IDLE.
- IDLE:
  - game_start: go to PLAYING and clear score to 0.
  - eat_pulse and game_over are ignored.
- PLAYING:
  - eat_pulse adds POINTS_PER_FOOD to score. The sum is computed 9 bits wide; if it exceeds MAX_SCORE, score is set to MAX_SCORE (saturate, no wrap).
  - game_over: go to OVER.
  - game_start: restart. score clears to 0 and the state stays PLAYING.
- OVER:
  - Entry cycle: if score > high_score, load high_score with score and set new_high. Otherwise clear new_high.
  - The alternation counter resets to 0 on entry.
  - game_start: go to PLAYING, clear score and new_high. high_score is retained.
  - eat_pulse and game_over are ignored.
- Simultaneous events in PLAYING:
  - eat_pulse with game_over: the eat is counted first, then the FSM enters OVER. The high-score compare uses the incremented score.
  - game_start with any other input: game_start wins. score goes to 0 and eat/over are dropped.
- display_score:
  - IDLE and PLAYING: shows score.
  - OVER: shows score for SHOW_CYCLES clocks, then high_score for SHOW_CYCLES clocks, repeating.
- Reset mid-game: all state is lost immediately, including high_score.

## Timing

- Reset values: score=0, high_score=0, new_high=0, display_score=0, playing=0, FSM=IDLE, alternation counter=0.
- score updates on the clock edge that samples eat_pulse, so the new value is visible one cycle after the pulse.
- high_score and new_high update on the edge that leaves PLAYING, which is the same edge that samples game_over.
- display_score is registered from the current score and state. It lags score by one cycle.
- playing follows the FSM state with no added latency.
- Alternation in OVER:
  - The first swap to high_score occurs SHOW_CYCLES clocks after OVER entry.
  - The counter is sized to hold SHOW_CYCLES-1.
- Back-to-back eat_pulse on consecutive cycles: each pulse is counted.

## Configuration

- SCORE_HISCORE_EN defined:
  - high_score register is present.
  - new_high is generated.
  - OVER alternates display_score as described.
- SCORE_HISCORE_EN undefined:
  - high_score is tied to 0 and new_high to 0.
  - No alternation counter is built.
  - display_score always shows score, including in OVER.
  - FSM and score behaviour are otherwise identical.

## Test plan

Benches use SHOW_CYCLES=4 unless noted.

- Reset then 5 eat pulses in IDLE -> score stays 0 and playing=0. Then game_start and 5 eats -> score=5, display_score=5 one cycle later.
- MAX_SCORE=99, POINTS_PER_FOOD=10: 12 eats -> score sequence 10..90, then 99, then held at 99.
- Score 7, game_over -> OVER, high_score=7, new_high=1. display_score shows 7 for 4 clocks, then 7 for 4 clocks.
- Restart and reach score 3, game_over -> high_score stays 7 and new_high=0. display_score alternates 3 (4 clocks) and 7 (4 clocks).
- In PLAYING at score 4, eat_pulse and game_over in the same cycle -> score=5 and high_score updated to 5 if it was lower. Separately, game_start with eat_pulse -> score=0.
- rst_n asserted mid-OVER -> all outputs 0 asynchronously and FSM in IDLE. With SCORE_HISCORE_EN undefined, repeat the game_over case -> high_score=0, new_high=0, display_score=score throughout.

Source files
------------

// File: rtl/score_counter.sv
// Snake game score keeper: saturating score, session high score and the display value.
// Optional high-score / game-over alternation feature is enabled by defining SCORE_HISCORE_EN.
module score_counter #(
    parameter int MAX_SCORE       = 99,
    parameter int POINTS_PER_FOOD = 1,
    parameter int SHOW_CYCLES     = 25_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       game_start,
    input  logic       eat_pulse,
    input  logic       game_over,
    output logic [7:0] score,
    output logic [7:0] high_score,
    output logic       new_high,
    output logic [7:0] display_score,
    output logic       playing
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PLAYING = 2'd1,
        ST_OVER    = 2'd2
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] score_q, score_d;
    logic       playing_q, playing_d;
    logic [7:0] display_q, display_d;
    logic [8:0] sum_s;

    // Reject configurations the two-digit display stage cannot show.
    if (MAX_SCORE < 1 || MAX_SCORE > 99) begin : g_bad_max
        $error("score_counter: MAX_SCORE must be in 1..99");
    end
    if (POINTS_PER_FOOD < 1 || POINTS_PER_FOOD > MAX_SCORE) begin : g_bad_points
        $error("score_counter: POINTS_PER_FOOD must be in 1..MAX_SCORE");
    end
    if (SHOW_CYCLES < 1) begin : g_bad_show
        $error("score_counter: SHOW_CYCLES must be at least 1");
    end

    // Next-state and score logic; game_start has priority over eat and over.
    always_comb begin
        state_d = state_q;
        score_d = score_q;
        sum_s   = {1'b0, score_q} + 9'(POINTS_PER_FOOD);
        case (state_q)
            ST_IDLE: begin
                if (game_start) begin
                    state_d = ST_PLAYING;
                    score_d = 8'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PLAYING: begin
                if (game_start) begin
                    score_d = 8'd0;
                end else begin
                    if (eat_pulse) begin
                        score_d = (sum_s > 9'(MAX_SCORE)) ? 8'(MAX_SCORE) : sum_s[7:0];
                    end else begin
                        score_d = score_q;
                    end
                    if (game_over) begin
                        state_d = ST_OVER;
                    end else begin
                        state_d = ST_PLAYING;
                    end
                end
            end
            ST_OVER: begin
                if (game_start) begin
                    state_d = ST_PLAYING;
                    score_d = 8'd0;
                end else begin
                    state_d = ST_OVER;
                end
            end
            default: begin
                state_d = ST_IDLE;
                score_d = 8'd0;
            end
        endcase
        playing_d = (state_d == ST_PLAYING);
    end

    // FSM, score and playing flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            score_q   <= 8'd0;
            playing_q <= 1'b0;
            display_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            score_q   <= score_d;
            playing_q <= playing_d;
            display_q <= display_d;
        end
    end

`ifdef SCORE_HISCORE_EN
    localparam int CNT_W = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SHOW_CYCLES - 1);

    logic [7:0]       high_q, high_d;
    logic             new_high_q, new_high_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sel_q, sel_d;
    logic             over_entry_s;

    // High-score compare uses score_d so a simultaneous eat is included.
    always_comb begin
        high_d       = high_q;
        new_high_d   = new_high_q;
        cnt_d        = cnt_q;
        sel_d        = sel_q;
        over_entry_s = (state_q == ST_PLAYING) && game_over && !game_start;
        if (over_entry_s) begin
            if (score_d > high_q) begin
                high_d     = score_d;
                new_high_d = 1'b1;
            end else begin
                new_high_d = 1'b0;
            end
        end else if ((state_q == ST_OVER) && game_start) begin
            new_high_d = 1'b0;
        end else begin
            new_high_d = new_high_q;
        end
        if (state_q != ST_OVER) begin
            cnt_d = {CNT_W{1'b0}};
            sel_d = 1'b0;
        end else if (cnt_q == CNT_MAX) begin
            cnt_d = {CNT_W{1'b0}};
            sel_d = ~sel_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        display_d = ((state_q == ST_OVER) && sel_q) ? high_q : score_q;
    end

    // High score and alternation registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            high_q     <= 8'd0;
            new_high_q <= 1'b0;
            cnt_q      <= {CNT_W{1'b0}};
            sel_q      <= 1'b0;
        end else begin
            high_q     <= high_d;
            new_high_q <= new_high_d;
            cnt_q      <= cnt_d;
            sel_q      <= sel_d;
        end
    end

    assign high_score = high_q;
    assign new_high   = new_high_q;
`else
    // Without the high-score feature the display simply mirrors the score.
    always_comb begin
        display_d = score_q;
    end

    assign high_score = 8'd0;
    assign new_high   = 1'b0;
`endif

    assign score         = score_q;
    assign playing       = playing_q;
    assign display_score = display_q;

endmodule

// File: tb/tb_score_counter.sv
// Directed bench for score_counter (SHOW_CYCLES=4); expectations follow SCORE_HISCORE_EN.
module tb_score_counter;

    logic       clk = 1'b0;
    logic       rst_n, gs, eat, go;
    logic [7:0] score, high_score, display_score;
    logic       new_high, playing;
    logic [7:0] score10, high10, disp10;
    logic       nh10, play10;

`ifdef SCORE_HISCORE_EN
    localparam bit HS_EN = 1'b1;
`else
    localparam bit HS_EN = 1'b0;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    score_counter #(.MAX_SCORE(99), .POINTS_PER_FOOD(1), .SHOW_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .game_start(gs), .eat_pulse(eat), .game_over(go),
        .score(score), .high_score(high_score), .new_high(new_high),
        .display_score(display_score), .playing(playing)
    );

    score_counter #(.MAX_SCORE(99), .POINTS_PER_FOOD(10), .SHOW_CYCLES(4)) dut10 (
        .clk(clk), .rst_n(rst_n), .game_start(gs), .eat_pulse(eat), .game_over(go),
        .score(score10), .high_score(high10), .new_high(nh10),
        .display_score(disp10), .playing(play10)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cycle(input logic g, input logic e, input logic o);
        gs  = g;
        eat = e;
        go  = o;
        @(posedge clk);
        #1;
        gs  = 1'b0;
        eat = 1'b0;
        go  = 1'b0;
    endtask

    typedef struct {
        logic g;
        logic e;
        logic o;
        int   s;
        int   d;
        int   p;
    } vec_t;

    vec_t vecs[12];

    initial begin
        rst_n = 1'b0;
        gs    = 1'b0;
        eat   = 1'b0;
        go    = 1'b0;

        // eats in IDLE ignored, then start and count five eats
        for (int i = 0; i < 5; i++) vecs[i] = '{1'b0, 1'b1, 1'b0, 0, 0, 0};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 0, 0, 1};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 1, 0, 1};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 2, 1, 1};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 3, 2, 1};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 4, 3, 1};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 5, 4, 1};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 5, 5, 1};

        repeat (2) @(posedge clk);
        #1;
        check("rst_score", score, 0);
        check("rst_high", high_score, 0);
        check("rst_new_high", new_high, 0);
        check("rst_display", display_score, 0);
        check("rst_playing", playing, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            cycle(vecs[i].g, vecs[i].e, vecs[i].o);
            check($sformatf("vec%0d_score", i), score, vecs[i].s);
            check($sformatf("vec%0d_display", i), display_score, vecs[i].d);
            check($sformatf("vec%0d_playing", i), playing, vecs[i].p);
        end

        // saturation with 10 points per food
        cycle(1'b1, 1'b0, 1'b0);
        check("sat_start", score10, 0);
        for (int k = 1; k <= 12; k++) begin
            cycle(1'b0, 1'b1, 1'b0);
            check($sformatf("sat_eat%0d", k), score10, (10 * k > 99) ? 99 : 10 * k);
        end
        check("back_to_back_score", score, 12);

        // first game over at 7
        cycle(1'b1, 1'b0, 1'b0);
        repeat (7) cycle(1'b0, 1'b1, 1'b0);
        check("game1_score", score, 7);
        cycle(1'b0, 1'b0, 1'b1);
        check("game1_playing", playing, 0);
        check("game1_high", high_score, HS_EN ? 7 : 0);
        check("game1_new_high", new_high, HS_EN ? 1 : 0);
        check("game1_disp_entry", display_score, 7);
        for (int k = 1; k <= 8; k++) begin
            cycle(1'b0, (k == 3), (k == 5));
            check($sformatf("game1_disp%0d", k), display_score, 7);
        end
        check("over_ignores_eat", score, 7);

        // second game ends at 3: high stays 7, display alternates
        cycle(1'b1, 1'b0, 1'b0);
        check("game2_playing", playing, 1);
        check("game2_new_high_clr", new_high, 0);
        check("game2_high_kept", high_score, HS_EN ? 7 : 0);
        check("game2_score_clr", score, 0);
        repeat (3) cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b1);
        check("game2_high", high_score, HS_EN ? 7 : 0);
        check("game2_new_high", new_high, 0);
        for (int k = 1; k <= 12; k++) begin
            cycle(1'b0, 1'b0, 1'b0);
            check($sformatf("alt_disp%0d", k), display_score,
                  (HS_EN && (((k - 1) / 4) % 2 == 1)) ? 7 : 3);
        end

        // asynchronous reset in the middle of OVER
        rst_n = 1'b0;
        #2;
        check("arst_score", score, 0);
        check("arst_high", high_score, 0);
        check("arst_new_high", new_high, 0);
        check("arst_display", display_score, 0);
        check("arst_playing", playing, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle(1'b0, 1'b1, 1'b0);
        check("arst_idle_eat", score, 0);

        // eat and over together: incremented score reaches the high score
        cycle(1'b1, 1'b0, 1'b0);
        repeat (4) cycle(1'b0, 1'b1, 1'b0);
        check("sim_score4", score, 4);
        cycle(1'b0, 1'b1, 1'b1);
        check("sim_score5", score, 5);
        check("sim_playing", playing, 0);
        check("sim_high", high_score, HS_EN ? 5 : 0);
        check("sim_new_high", new_high, HS_EN ? 1 : 0);

        // game_start wins over eat and over
        cycle(1'b1, 1'b1, 1'b0);
        check("restart_eat_score", score, 0);
        check("restart_eat_playing", playing, 1);
        check("restart_new_high", new_high, 0);
        check("restart_high_kept", high_score, HS_EN ? 5 : 0);
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        check("play_score2", score, 2);
        cycle(1'b1, 1'b1, 1'b0);
        check("gs_eat_score", score, 0);
        cycle(1'b1, 1'b0, 1'b1);
        check("gs_over_score", score, 0);
        check("gs_over_playing", playing, 1);
        cycle(1'b0, 1'b1, 1'b0);
        check("resume_score", score, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
